// File: rtl/masked_sbox_scheduler.sv
// Purpose: sequences the bytes of a masked 16-byte state (SubBytes) or 4-byte word
//          (SubWord) through one shared, externally instantiated pipelined masked
//          S-box. A byte is issued only in a cycle with fresh randomness. Results are
//          captured strictly in issue order after SBOX_LATENCY edges. Shares are never combined.
// Ports:   in_clock/in_reset (async, active-high); in_valid/out_ready operand handshake
//          (ready only in IDLE); in_word_mode, in_state operand; in_rand_valid/in_rand
//          with out_rand_ready as the issue strobe; out_sbox_a/out_sbox_random to the
//          S-box; in_sbox_b from the S-box; out_valid/in_ready/out_state result handshake.
module masked_sbox_scheduler #(
  parameter int NUM_SHARES   = 2,
  parameter int STAGE_TYPE   = 0,
  parameter int SBOX_LATENCY = 3,
  // Fresh bits per issue: one multiplication-mask set per share pair, and the
  // pipelined inverter flavour (STAGE_TYPE != 0) needs twice as many.
  localparam int NUM_RANDOM  = (NUM_SHARES * (NUM_SHARES - 1) / 2) * ((STAGE_TYPE == 0) ? 18 : 36)
) (
  input  logic                                in_clock,
  input  logic                                in_reset,
  input  logic                                in_valid,
  output logic                                out_ready,
  input  logic                                in_word_mode,
  input  logic [NUM_SHARES-1:0][15:0][7:0]    in_state,
  input  logic                                in_rand_valid,
  input  logic [NUM_RANDOM-1:0]               in_rand,
  output logic                                out_rand_ready,
  output logic [NUM_SHARES-1:0][7:0]          out_sbox_a,
  output logic [NUM_RANDOM-1:0]               out_sbox_random,
  input  logic [NUM_SHARES-1:0][7:0]          in_sbox_b,
  output logic                                out_valid,
  input  logic                                in_ready,
  output logic [NUM_SHARES-1:0][15:0][7:0]    out_state
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                             state_q, state_d;
  logic [4:0]                         issue_idx_q, issue_idx_d;
  logic [4:0]                         cap_idx_q, cap_idx_d;
  logic                               word_mode_q, word_mode_d;
  logic [NUM_SHARES-1:0][15:0][7:0]   operand_q, operand_d;
  logic [NUM_SHARES-1:0][15:0][7:0]   result_q, result_d;
  // One flag per S-box pipeline stage; the tail flag marks a valid S-box output.
  logic [SBOX_LATENCY-1:0]            inflight_q, inflight_d;

  logic       issue;
  logic       capture;
  logic [4:0] last_idx;

  assign issue    = (state_q == ISSUE) && in_rand_valid;
  assign capture  = inflight_q[SBOX_LATENCY-1];
  assign last_idx = word_mode_q ? 5'd3 : 5'd15;

  assign out_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_state = result_q;

  always_comb begin
    state_d         = state_q;
    issue_idx_d     = issue_idx_q;
    cap_idx_d       = cap_idx_q;
    word_mode_d     = word_mode_q;
    operand_d       = operand_q;
    result_d        = result_q;
    out_sbox_a      = '0;
    out_sbox_random = '0;
    out_rand_ready  = 1'b0;

    // The tracking pipe advances every cycle, whatever the FSM state.
    inflight_d    = inflight_q << 1;
    inflight_d[0] = issue;

    // Results return in issue order, so the capture counter alone names the byte.
    if (capture) begin
      for (int s = 0; s < NUM_SHARES; s++) begin
        result_d[s][cap_idx_q[3:0]] = in_sbox_b[s];
      end
      cap_idx_d = cap_idx_q + 5'd1;
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          operand_d   = in_state;
          // Bytes that are never issued (4..15 in word mode) pass straight through.
          result_d    = in_state;
          word_mode_d = in_word_mode;
          issue_idx_d = '0;
          cap_idx_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (in_rand_valid) begin
          for (int s = 0; s < NUM_SHARES; s++) begin
            out_sbox_a[s] = operand_q[s][issue_idx_q[3:0]];
          end
          out_sbox_random = in_rand;
          out_rand_ready  = 1'b1;
          issue_idx_d     = issue_idx_q + 5'd1;
          if (issue_idx_q == last_idx) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (capture && (cap_idx_q == last_idx)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (in_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      state_q     <= IDLE;
      issue_idx_q <= '0;
      cap_idx_q   <= '0;
      word_mode_q <= 1'b0;
      operand_q   <= '0;
      result_q    <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      cap_idx_q   <= cap_idx_d;
      word_mode_q <= word_mode_d;
      operand_q   <= operand_d;
      result_q    <= result_d;
      inflight_q  <= inflight_d;
    end
  end

endmodule
